// File: rtl/posit_pkg.sv
// Shared types and constants for the posit(16,1) to binary32 converter.
// The stage-1 payload carries the biased float exponent, not the raw scale.
package posit_pkg;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int RS = 5;
    localparam int FS = N - 3 - ES;

    localparam logic [7:0]  FP32_BIAS = 8'd127;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic          sign;
        logic          zero;
        logic          nar;
        logic [7:0]    biased;
        logic [FS-1:0] frac;
    } s1_payload_t;

endpackage

// File: rtl/posit16_to_fp32_pipe_stage.sv
// One valid/ready register slice: a valid bit plus a data register.
// The slice refills in the same cycle its contents are taken downstream.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/posit16_to_fp32.sv
// Two-stage converter from decoded posit(16,1) fields to binary32.
// Every posit(16,1) value maps exactly, so no rounding logic exists.
module posit16_to_fp32 #(
    parameter int N  = posit_pkg::N,
    parameter int ES = posit_pkg::ES,
    parameter int RS = posit_pkg::RS,
    parameter int FS = N - 3 - ES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [RS-1:0] in_regi,
    input  logic [ES-1:0] in_expo,
    input  logic [FS-1:0] in_frac,
    input  logic          in_zero,
    input  logic          in_nar,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [7:0]    nar_count
);

    import posit_pkg::*;

    localparam int SW = $bits(s1_payload_t);
    localparam int XW = RS + 1 + ES;

    logic [XW-1:0] scale;
    s1_payload_t   s1_d;
    s1_payload_t   s1_q;
    logic [SW-1:0] s1_raw;
    logic          s1_valid;
    logic          s2_ready;
    logic [31:0]   s2_d;

    // scale = k * 2^ES + e, formed by sign-extending k and appending e
    always_comb begin
        scale       = {in_regi[RS-1], in_regi, in_expo};
        s1_d        = '0;
        s1_d.sign   = in_sign;
        s1_d.zero   = in_zero;
        s1_d.nar    = in_nar;
        s1_d.frac   = in_frac;
        s1_d.biased = 8'($signed(scale)) + FP32_BIAS;
    end

    pipe_stage #(
        .W(SW)
    ) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_d),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_data (s1_raw)
    );

    assign s1_q = s1_payload_t'(s1_raw);

    // NaR wins over zero when the decoder flags both
    always_comb begin
        s2_d = {s1_q.sign, s1_q.biased, s1_q.frac, {(23-FS){1'b0}}};
        if (s1_q.nar) begin
            s2_d = FP32_QNAN;
        end else if (s1_q.zero) begin
            s2_d = 32'h0;
        end
    end

    pipe_stage #(
        .W(32)
    ) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_data  (s2_d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            nar_count <= 8'd0;
        end else if (in_valid && in_ready && in_nar && nar_count != 8'hFF) begin
            nar_count <= nar_count + 8'd1;
        end
    end

endmodule

// File: doc/posit16_to_fp32.md
# posit16_to_fp32

Two-stage pipelined converter from decoded posit(16,1) fields to IEEE-754 binary32, with valid/ready flow control on both sides. It sits directly downstream of the posit(16,1) field decoder and consumes its sign, regime, exponent bit, 12-bit fraction and zero/NaR flags. It packs those fields into a float32 word for the FP datapath. A saturating NaR counter is provided for debug visibility.

## Interface
Parameters:
- N, 16, posit width
- ES, 1, posit exponent bits
- RS, 5, regime field width (signed, two's complement)
- FS, 12, fraction width (N-3-ES)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decoded posit fields present
- in_ready  output  1  converter accepts this cycle
- in_sign  input  1  posit sign
- in_regi  input  RS  regime value k, signed, range -15..14
- in_expo  input  ES  posit exponent bit
- in_frac  input  FS  fraction, hidden bit excluded, MSB-aligned
- in_zero  input  1  posit is zero (decoder allzero)
- in_nar  input  1  posit is NaR (decoder inf)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts this cycle
- out_data  output  32  binary32 result
- nar_count  output  8  saturating count of NaR inputs accepted

## Operation
- Transfer on input when in_valid & in_ready; transfer on output when out_valid & out_ready.
- Stage 1 registers sign, flags and frac, and computes scale = 2*in_regi + in_expo as a 7-bit signed value (range -30..29). It then registers biased = scale + 127 as 8 bits, range 97..156.
- Stage 2 forms the result:
  - NaR: 0x7FC00000 (quiet NaN, sign 0). in_nar has priority over in_zero.
  - Zero: 0x00000000.
  - Otherwise: {sign, biased[7:0], frac[11:0], 11'b0}.
- No rounding is needed; every posit(16,1) value is exactly representable in binary32. No denormals, infinities or overflow can occur.
- Decoder fraction is magnitude-domain. Sign comes only from in_sign.
- nar_count increments on each accepted input with in_nar=1 and holds at 255.

## Timing
- Latency: exactly 2 cycles from input transfer to out_valid, assuming no backpressure. Throughput is 1 result per cycle.
- State per stage: a valid bit plus a data register.
  - s2 loads when ~v2 | out_ready.
  - s1 loads when ~v1 | (s1 moves into s2).
- in_ready = ~v1 | ~v2 | out_ready. This path is combinational from out_ready and is intentional.
- When out_valid=1 and out_ready=0, out_data and out_valid hold stable until the transfer.
- in_valid with in_ready=0: inputs are ignored and no state changes.
- Full pipeline (v1=v2=1) with out_ready=1 and in_valid=1: s2 retires, s1 shifts into s2 and the new input loads into s1 in the same cycle. No bubble is inserted.
- Reset values: v1=v2=0, out_valid=0, out_data=0, nar_count=0. in_ready=1 during and after reset.
- Reset mid-operation discards both stages with no partial output. The first result after reset appears 2 cycles after the first post-reset accept.

## Structure
- Shared package posit_pkg holds:
  - N, ES, RS, FS
  - FP32_BIAS=127
  - FP32_QNAN=32'h7FC00000
  - the stage-1 payload struct: sign, zero, nar, biased[7:0], frac[FS-1:0]
- One sub-module, pipe_stage: a parameterised-width valid/ready register slice. It is instantiated twice, with the conversion logic placed between the instances.

## Test plan
- Basic conversion. Stimulus: sign0, regi=0, expo=1, frac=0x800, out_ready held 1. Required: out_data=0x40400000 (3.0) exactly 2 cycles after accept.
- Negative value and minimum scale.
  - sign1, regi=-1 (5'h1F), expo0, frac0 -> 0xBE800000.
  - regi=-15, expo0, frac0 -> 0x30800000.
- Special values.
  - in_zero=1 -> 0x00000000.
  - in_nar=1 with in_zero=1 -> 0x7FC00000, and nar_count increments to 1.
- Backpressure. Stream 5 back-to-back inputs while holding out_ready=0 for 4 cycles. Required:
  - in_ready drops after 2 accepts.
  - out_data is stable while stalled.
  - All 5 results emerge in order with no loss or duplication.
- Reset mid-stream. Assert rst with v1=v2=1. Required:
  - The next cycle shows out_valid=0 and nar_count=0.
  - The stale results never appear on the output.
- NaR count saturation. Feed 300 NaR inputs. Required: nar_count stops at 255.
